layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_sequencer_if.sv | 31 +++
 rtl/layer_sequencer.sv | 118 +++++++++++
 tb/tb_layer_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/layer_sequencer_if.sv
// Purpose: control/status bundle between a layer controller and layer_sequencer.
// master: drives start/abort/config/accum_done, observes sequencer outputs.
// slave : layer_sequencer side.
interface layer_sequencer_if;
    localparam int unsigned CH_W = 6;
    localparam int unsigned NK_W = 13;

    logic            start;
    logic            abort;
    logic [1:0]      conv_or_fc;
    logic [CH_W-1:0] max_ch;
    logic [NK_W-1:0] max_nk;
    logic            accum_done;
    logic [CH_W-1:0] ch;
    logic [NK_W-1:0] nk;
    logic            accum_activate;
    logic            bias_rd_en;
    logic            busy;
    logic            layer_done;
    logic            cfg_err;

    modport master (
        output start, abort, conv_or_fc, max_ch, max_nk, accum_done,
        input  ch, nk, accum_activate, bias_rd_en, busy, layer_done, cfg_err
    );

    modport slave (
        input  start, abort, conv_or_fc, max_ch, max_nk, accum_done,
        output ch, nk, accum_activate, bias_rd_en, busy, layer_done, cfg_err
    );
endinterface

// File: rtl/layer_sequencer.sv
// Purpose: walks (channel, kernel) passes of one CNN layer, launching one
// accumulation pass per pair and waiting for its completion pulse.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   bus (slave)     - start/abort/conv_or_fc/max_ch/max_nk/accum_done in;
//                     ch/nk/accum_activate/bias_rd_en/busy/layer_done/cfg_err out
module layer_sequencer (
    input  logic               clk,
    input  logic               rst_n,
    layer_sequencer_if.slave   bus
);
    localparam int unsigned CH_W = 6;
    localparam int unsigned NK_W = 13;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_ADVANCE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [NK_W-1:0] nk_q, nk_d;
    logic [CH_W-1:0] max_ch_q, max_ch_d;
    logic [NK_W-1:0] max_nk_q, max_nk_d;
    logic            cfg_err_d;
    logic            cfg_err_q;
    logic            accum_activate_q;
    logic            bias_rd_en_q;
    logic            busy_q;
    logic            layer_done_q;

    // Next-state and counter update; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        nk_d      = nk_q;
        max_ch_d  = max_ch_q;
        max_nk_d  = max_nk_q;
        cfg_err_d = 1'b0;
        if (bus.abort) begin
            state_d = ST_IDLE;
            ch_d    = '0;
            nk_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.conv_or_fc[1]) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            // FC layers make a single pass per kernel
                            max_ch_d = bus.conv_or_fc[0] ? '0 : bus.max_ch;
                            max_nk_d = bus.max_nk;
                            ch_d     = '0;
                            nk_d     = '0;
                            state_d  = ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (bus.accum_done) state_d = ST_ADVANCE;
                end
                ST_ADVANCE: begin
                    // channel first, then kernel, then finish
                    if (ch_q < max_ch_q) begin
                        ch_d    = ch_q + CH_W'(1);
                        state_d = ST_ISSUE;
                    end else if (nk_q < max_nk_q) begin
                        ch_d    = '0;
                        nk_d    = nk_q + NK_W'(1);
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, counters, and state-decoded outputs registered from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            ch_q             <= '0;
            nk_q             <= '0;
            max_ch_q         <= '0;
            max_nk_q         <= '0;
            cfg_err_q        <= 1'b0;
            accum_activate_q <= 1'b0;
            bias_rd_en_q     <= 1'b0;
            busy_q           <= 1'b0;
            layer_done_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            ch_q             <= ch_d;
            nk_q             <= nk_d;
            max_ch_q         <= max_ch_d;
            max_nk_q         <= max_nk_d;
            cfg_err_q        <= cfg_err_d;
            accum_activate_q <= (state_d == ST_ISSUE);
            bias_rd_en_q     <= (state_d == ST_ISSUE) && (ch_d == '0);
            busy_q           <= (state_d != ST_IDLE);
            layer_done_q     <= (state_d == ST_DONE);
        end
    end

    assign bus.ch             = ch_q;
    assign bus.nk             = nk_q;
    assign bus.accum_activate = accum_activate_q;
    assign bus.bias_rd_en     = bias_rd_en_q;
    assign bus.busy           = busy_q;
    assign bus.layer_done     = layer_done_q;
    assign bus.cfg_err        = cfg_err_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Purpose: self-checking bench for layer_sequencer (vector table plus
// hand-written multi-cycle sequences).
module tb_layer_sequencer;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    layer_sequencer_if bus();

    layer_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        ab;
        logic [1:0]  cf;
        logic [5:0]  mc;
        logic [12:0] mk;
        logic        ad;
        logic [23:0] exp_o;
    } vec_t;

    vec_t vq[$];

    // {activate, bias, busy, layer_done, cfg_err, ch, nk}
    function automatic logic [23:0] outs();
        return {bus.accum_activate, bus.bias_rd_en, bus.busy, bus.layer_done,
                bus.cfg_err, bus.ch, bus.nk};
    endfunction

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp_v);
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp_v);
        end
    endtask

    task automatic add(input logic st, input logic ab, input logic [1:0] cf,
                       input logic [5:0] mc, input logic [12:0] mk, input logic ad,
                       input logic a, input logic b, input logic bz, input logic d,
                       input logic e, input logic [5:0] c, input logic [12:0] n);
        vec_t v;
        v.st = st; v.ab = ab; v.cf = cf; v.mc = mc; v.mk = mk; v.ad = ad;
        v.exp_o = {a, b, bz, d, e, c, n};
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs a full layer, answering each activate with accum_done one cycle later.
    task automatic run_layer(input logic [1:0] cf, input logic [5:0] mc, input logic [12:0] mk);
        int   acts = 0;
        int   cyc = 0;
        bit   done = 0;
        bit   pend = 0;
        int   ec = 0;
        int   en = 0;
        int   emc;
        int   exp_acts;
        emc      = (cf == 2'b01) ? 0 : int'(mc);
        exp_acts = (emc + 1) * (int'(mk) + 1);
        bus.start = 1'b1; bus.conv_or_fc = cf; bus.max_ch = mc; bus.max_nk = mk;
        tick();
        bus.start = 1'b0; bus.max_ch = 6'd63; bus.max_nk = 13'd0;
        while (!done && cyc < 4 * exp_acts + 20) begin
            bus.accum_done = pend;
            pend = 1'b0;
            if (bus.accum_activate) begin
                check("pass_chnk", 24'({bus.ch, bus.nk}), 24'({6'(ec), 13'(en)}));
                check("pass_bias", 24'(bus.bias_rd_en), 24'(ec == 0));
                acts++;
                pend = 1'b1;
                if (ec < emc) ec++;
                else begin ec = 0; en++; end
            end
            if (bus.layer_done) done = 1'b1;
            tick();
            cyc++;
        end
        bus.accum_done = 1'b0;
        check("layer_done_seen", 24'(done), 24'(1));
        check("activate_count", 24'(acts), 24'(exp_acts));
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.conv_or_fc = 2'b00;
        bus.max_ch = '0; bus.max_nk = '0; bus.accum_done = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick(); tick();
        check("reset_state", outs(), 24'h0);
        #2 rst_n = 1'b1;
        tick();
        check("post_reset_idle", outs(), 24'h0);

        // CONV max_ch=1 max_nk=1, accum_done 3 cycles after each activate
        add(1,0,2'b00,1,1,0, 1,1,1,0,0,0,0);
        add(0,0,2'b00,7,9,1, 0,0,1,0,0,0,0); // accum_done in ISSUE ignored
        add(0,0,2'b00,7,9,0, 0,0,1,0,0,0,0);
        add(1,0,2'b00,7,9,0, 0,0,1,0,0,0,0); // start in WAIT ignored
        add(0,0,2'b00,7,9,1, 0,0,1,0,0,0,0);
        add(0,0,2'b00,7,9,0, 1,0,1,0,0,1,0);
        add(0,0,2'b00,7,9,0, 0,0,1,0,0,1,0);
        add(0,0,2'b00,7,9,0, 0,0,1,0,0,1,0);
        add(0,0,2'b00,7,9,0, 0,0,1,0,0,1,0);
        add(0,0,2'b00,7,9,1, 0,0,1,0,0,1,0);
        add(0,0,2'b00,7,9,0, 1,1,1,0,0,0,1);
        add(0,0,2'b00,7,9,0, 0,0,1,0,0,0,1);
        add(0,0,2'b00,7,9,0, 0,0,1,0,0,0,1);
        add(0,0,2'b00,7,9,0, 0,0,1,0,0,0,1);
        add(0,0,2'b00,7,9,1, 0,0,1,0,0,0,1);
        add(0,0,2'b00,7,9,0, 1,0,1,0,0,1,1);
        add(0,0,2'b00,7,9,0, 0,0,1,0,0,1,1);
        add(0,0,2'b00,7,9,0, 0,0,1,0,0,1,1);
        add(0,0,2'b00,7,9,0, 0,0,1,0,0,1,1);
        add(0,0,2'b00,7,9,1, 0,0,1,0,0,1,1);
        add(0,0,2'b00,7,9,0, 0,0,1,1,0,1,1); // DONE
        add(0,0,2'b00,7,9,0, 0,0,0,0,0,1,1);
        add(0,0,2'b00,7,9,1, 0,0,0,0,0,1,1); // accum_done in IDLE ignored
        add(0,0,2'b00,7,9,0, 0,0,0,0,0,1,1);
        // FC max_ch=5 max_nk=2: ch forced to 0
        add(1,0,2'b01,5,2,0, 1,1,1,0,0,0,0);
        add(0,0,2'b00,7,9,0, 0,0,1,0,0,0,0);
        add(0,0,2'b00,7,9,1, 0,0,1,0,0,0,0);
        add(0,0,2'b00,7,9,0, 1,1,1,0,0,0,1);
        add(0,0,2'b00,7,9,0, 0,0,1,0,0,0,1);
        add(0,0,2'b00,7,9,1, 0,0,1,0,0,0,1);
        add(0,0,2'b00,7,9,0, 1,1,1,0,0,0,2);
        add(0,0,2'b00,7,9,0, 0,0,1,0,0,0,2);
        add(0,0,2'b00,7,9,1, 0,0,1,0,0,0,2);
        add(0,0,2'b00,7,9,0, 0,0,1,1,0,0,2);
        add(0,0,2'b00,7,9,0, 0,0,0,0,0,0,2);
        // illegal layer types
        add(1,0,2'b11,3,3,0, 0,0,0,0,1,0,2);
        add(0,0,2'b11,3,3,0, 0,0,0,0,0,0,2);
        add(1,0,2'b10,3,3,0, 0,0,0,0,1,0,2);
        add(0,0,2'b00,3,3,0, 0,0,0,0,0,0,2);
        // abort with accum_done in WAIT of pass (1,0)
        add(1,0,2'b00,1,1,0, 1,1,1,0,0,0,0);
        add(0,0,2'b00,7,9,0, 0,0,1,0,0,0,0);
        add(0,0,2'b00,7,9,1, 0,0,1,0,0,0,0);
        add(0,0,2'b00,7,9,0, 1,0,1,0,0,1,0);
        add(0,0,2'b00,7,9,0, 0,0,1,0,0,1,0);
        add(0,1,2'b00,7,9,1, 0,0,0,0,0,0,0);
        add(0,0,2'b00,7,9,0, 0,0,0,0,0,0,0);
        add(1,1,2'b00,1,1,0, 0,0,0,0,0,0,0); // abort beats start
        add(1,0,2'b00,1,1,0, 1,1,1,0,0,0,0); // restart at (0,0)
        add(0,1,2'b00,7,9,0, 0,0,0,0,0,0,0);

        for (int i = 0; i < vq.size(); i++) begin
            bus.start = vq[i].st; bus.abort = vq[i].ab; bus.conv_or_fc = vq[i].cf;
            bus.max_ch = vq[i].mc; bus.max_nk = vq[i].mk; bus.accum_done = vq[i].ad;
            tick();
            check($sformatf("vec%0d", i), outs(), vq[i].exp_o);
        end
        bus.start = 1'b0; bus.abort = 1'b0; bus.accum_done = 1'b0;
        tick();

        // pass-count and ordering over several shapes, incl. full nk range
        run_layer(2'b00, 6'd2, 13'd3);
        run_layer(2'b00, 6'd0, 13'd0);
        run_layer(2'b01, 6'd63, 13'd4);
        run_layer(2'b00, 6'd63, 13'd1);
        run_layer(2'b01, 6'd0, 13'd8191);

        // asynchronous reset while waiting on pass nk=5
        begin
            int  cyc = 0;
            bit  hit = 0;
            bit  pend = 0;
            bus.start = 1'b1; bus.conv_or_fc = 2'b00; bus.max_ch = 6'd0; bus.max_nk = 13'd9;
            tick();
            bus.start = 1'b0;
            while (!hit && cyc < 100) begin
                bus.accum_done = pend;
                pend = 1'b0;
                if (bus.accum_activate) begin
                    if (bus.nk == 13'd5) hit = 1'b1;
                    else pend = 1'b1;
                end
                if (!hit) begin
                    tick();
                    cyc++;
                end
            end
            bus.accum_done = 1'b0;
            check("reach_nk5", 24'(hit), 24'(1));
            tick();
            check("wait_nk5", outs(), {5'b00100, 6'd0, 13'd5});
            #2 rst_n = 1'b0;
            #1 check("async_reset", outs(), 24'h0);
            tick();
            check("reset_held", outs(), 24'h0);
            #3 rst_n = 1'b1;
            for (int i = 0; i < 4; i++) begin
                bus.accum_done = i[0];
                tick();
                check($sformatf("idle_after_reset%0d", i), outs(), 24'h0);
            end
            bus.accum_done = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
